// File: rtl/data_memory_pkg.sv
// Shared definitions for the data memory: access-size encodings.
package data_memory_pkg;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;
    localparam logic [1:0] MEM_RSVD = 2'd3;

endpackage

// File: rtl/data_memory_load_extend.sv
// Load lane selection and sign/zero extension for byte, half and word loads.
module load_extend
    import data_memory_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        unsgn,
    output logic [31:0] value
);

    logic [7:0]  b;
    logic [15:0] h;
    logic        bs;
    logic        hs;

    always_comb begin
        b     = word[8*offset +: 8];
        h     = offset[1] ? word[31:16] : word[15:0];
        bs    = ~unsgn & b[7];
        hs    = ~unsgn & h[15];
        value = word;
        case (size)
            MEM_BYTE: value = {{24{bs}}, b};
            MEM_HALF: value = {{16{hs}}, h};
            default:  value = word;
        endcase
    end

endmodule

// File: rtl/data_memory.sv
// Word-organised little-endian data memory with sized loads/stores,
// alignment/range checking and a sticky first-error capture.
module data_memory
    import data_memory_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MisalignErr,
    output logic        RangeErr,
    output logic        ErrSticky,
    output logic [31:0] LastErrAddr
);

    localparam int          IW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH);

    logic [31:0]   mem [DEPTH];
    logic          active;
    logic          err;
    logic          wr_en;
    logic          mis;
    logic [31:0]   offs;
    logic [IW-1:0] idx;
    logic [1:0]    sz;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   load_val;

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
    assign offs   = Addr - BASE_ADDR;
    assign idx    = offs[IW+1:2];
    assign active = MemRead | MemWrite;
    assign sz     = (MemSize == MEM_RSVD) ? MEM_WORD : MemSize;

    always_comb begin
        mis   = 1'b0;
        be    = 4'b1111;
        wlane = WriteData;
        case (sz)
            MEM_BYTE: begin
                be    = 4'b0001 << offs[1:0];
                wlane = {4{WriteData[7:0]}};
            end
            MEM_HALF: begin
                mis   = offs[0];
                be    = 4'b0011 << {offs[1], 1'b0};
                wlane = {2{WriteData[15:0]}};
            end
            default: begin
                mis = |offs[1:0];
            end
        endcase
    end

    assign MisalignErr = active & mis;
    assign RangeErr    = active & (offs >= SPAN);
    assign err         = MisalignErr | RangeErr;
    assign wr_en       = MemWrite & ~err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wlane[8*k +: 8];
                end
            end
        end
    end

    load_extend u_ext (
        .word   (mem[idx]),
        .offset (offs[1:0]),
        .size   (sz),
        .unsgn  (MemUnsigned),
        .value  (load_val)
    );

    // Faulting or inactive loads present zero, never stale data.
    assign ReadData = (rst_n && MemRead && !err) ? load_val : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ErrSticky   <= 1'b0;
            LastErrAddr <= '0;
        end else if (err && !ErrSticky) begin
            ErrSticky   <= 1'b1;
            LastErrAddr <= Addr;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// Randomised scoreboard bench for data_memory against a byte-array model.
module tb_data_memory;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = 2'd0;
    logic        MemUnsigned = 1'b0;
    logic [31:0] Addr = '0;
    logic [31:0] WriteData = '0;
    logic [31:0] ReadData;
    logic        MisalignErr;
    logic        RangeErr;
    logic        ErrSticky;
    logic [31:0] LastErrAddr;

    data_memory dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .Addr        (Addr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .MisalignErr (MisalignErr),
        .RangeErr    (RangeErr),
        .ErrSticky   (ErrSticky),
        .LastErrAddr (LastErrAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        mis;
        logic        rng;
        logic        sticky;
        logic [31:0] last;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad = 0;
    logic [7:0]  ref_mem [1024];
    bit          m_sticky;
    logic [31:0] m_last;

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
        m_sticky = 1'b0;
        m_last   = '0;
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk({e.name, " rdata"}, ReadData, e.rdata);
            chk({e.name, " misalign"}, 32'(MisalignErr), 32'(e.mis));
            chk({e.name, " range"}, 32'(RangeErr), 32'(e.rng));
            chk({e.name, " sticky"}, 32'(ErrSticky), 32'(e.sticky));
            chk({e.name, " lastaddr"}, LastErrAddr, e.last);
        end
    end

    // Called at posedge+1; returns at the following posedge+1.
    task automatic access(string n, bit rd, bit wr, logic [1:0] size,
                          bit uns, logic [31:0] addr, logic [31:0] wd);
        exp_t        e;
        int          nb;
        bit          mis;
        bit          rng;
        bit          err;
        logic [31:0] v;
        MemRead     = rd;
        MemWrite    = wr;
        MemSize     = size;
        MemUnsigned = uns;
        Addr        = addr;
        WriteData   = wd;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis = (rd || wr) && (addr % nb != 0);
        rng = (rd || wr) && (addr >= 32'd1024);
        err = mis || rng;
        v   = '0;
        if (rd && !err) begin
            for (int k = 0; k < nb; k++)
                v |= 32'(ref_mem[addr + k]) << (8 * k);
            if (!uns && nb < 4 && v[8*nb-1])
                v |= ~((32'd1 << (8 * nb)) - 32'd1);
        end
        e.name   = n;
        e.rdata  = v;
        e.mis    = mis;
        e.rng    = rng;
        e.sticky = m_sticky;
        e.last   = m_last;
        sbq.push_back(e);
        @(posedge clk);
        if (wr && !err)
            for (int k = 0; k < nb; k++)
                ref_mem[addr + k] = wd[8*k +: 8];
        if (err && !m_sticky) begin
            m_sticky = 1'b1;
            m_last   = addr;
        end
        #1;
    endtask

    initial begin
        bit          rd;
        bit          wr;
        logic [31:0] a;
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        access("lw 0x0", 1, 0, 2, 0, 32'h0, 0);
        access("lw 0x3fc", 1, 0, 2, 0, 32'h3FC, 0);
        access("sw 0x10", 0, 1, 2, 0, 32'h10, 32'h80FF7F01);
        access("lb 0x10", 1, 0, 0, 0, 32'h10, 0);
        access("lb 0x13", 1, 0, 0, 0, 32'h13, 0);
        access("lbu 0x13", 1, 0, 0, 1, 32'h13, 0);
        access("lh 0x12", 1, 0, 1, 0, 32'h12, 0);
        access("lhu 0x10", 1, 0, 1, 1, 32'h10, 0);
        access("sw 0x20", 0, 1, 2, 0, 32'h20, 32'h11223344);
        access("sb 0x21", 0, 1, 0, 0, 32'h21, 32'h000000AA);
        access("sh 0x22", 0, 1, 1, 0, 32'h22, 32'h0000BEEF);
        access("lw 0x20", 1, 0, 2, 0, 32'h20, 0);
        access("sw 0x22 mis", 0, 1, 2, 0, 32'h22, 32'hDEADBEEF);
        access("lw 0x400 rng", 1, 0, 2, 0, 32'h400, 0);
        access("lw 0x20 kept", 1, 0, 2, 0, 32'h20, 0);
        access("sw 0x30", 0, 1, 2, 0, 32'h30, 32'h9);
        access("rw 0x30 old", 1, 1, 2, 0, 32'h30, 32'h5);
        access("lw 0x30 new", 1, 0, 2, 0, 32'h30, 0);
        access("sw 0x40", 0, 1, 2, 0, 32'h40, 32'h12345678);

        MemRead   = 1'b1;
        MemWrite  = 1'b1;
        MemSize   = 2'd2;
        Addr      = 32'h40;
        WriteData = 32'hCAFEBABE;
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst sticky", 32'(ErrSticky), 32'd0);
        chk("async rst lastaddr", LastErrAddr, 32'd0);
        chk("async rst rdata", ReadData, 32'd0);
        @(posedge clk);
        #3;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        access("lw 0x40 after rst", 1, 0, 2, 0, 32'h40, 0);

        repeat (400) begin
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0)
                a = $urandom;
            else
                a = 32'($urandom_range(0, 255));
            access("rand", rd, wr, 2'($urandom_range(0, 3)),
                   bit'($urandom_range(0, 1)), a, $urandom);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
